// File: rtl/rv32i_types.sv
// Shared branch-prediction types: 2-bit local table state and the in-flight
// branch queue entry carried from fetch to execute.
package rv32i_types;

  typedef enum logic [1:0] {
    snt = 2'b00,
    wnt = 2'b01,
    wt  = 2'b10,
    st  = 2'b11
  } prediction_t;

  typedef struct packed {
    logic [31:0] pc;
    prediction_t prediction;
    logic [31:0] pc_prediction;
  } bq_entry_t;

endpackage

// File: rtl/bq_fifo.sv
// Circular buffer of bq_entry_t with push/pop gating and a flush that wins
// over both push and pop on the same edge.
module bq_fifo
  import rv32i_types::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  bq_entry_t        wdata,
  input  logic             pop,
  input  logic             flush,
  output bq_entry_t        rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  bq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   cnt;
  logic             push_ok, pop_ok;

  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop_ok)  head <= head + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[tail] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; resolves the head against
// execute results, trains the local table and redirects fetch on a wrong next PC.
module branch_resolve_queue
  import rv32i_types::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_pc,
  input  logic [1:0]        fetch_prediction,
  input  logic [31:0]       fetch_pc_prediction,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count,
  input  logic              resolve_valid,
  input  logic [31:0]       resolve_pc,
  input  logic              resolve_is_branch,
  input  logic              resolve_taken,
  input  logic [31:0]       resolve_target,
  output logic              update,
  output logic              correct,
  output logic [31:0]       pc_update,
  output logic [1:0]        previous_prediction,
  output logic [31:0]       calculated_target,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic              order_err
);

  bq_entry_t   wentry, head;
  logic        pop_fire, pred_taken, mispredict, flush;
  logic [31:0] actual_next;

  assign wentry = '{pc: fetch_pc, prediction: prediction_t'(fetch_prediction),
                    pc_prediction: fetch_pc_prediction};

  bq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch_valid),
    .wdata (wentry),
    .pop   (resolve_valid),
    .flush (flush),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign pop_fire    = resolve_valid && !empty;
  assign pred_taken  = (head.prediction == wt) || (head.prediction == st);
  assign actual_next = (resolve_is_branch && resolve_taken) ? resolve_target : head.pc + 32'd4;
  // Non-branches mispredict too when the table aliased them to a taken target.
  assign mispredict  = (head.pc_prediction != actual_next);
  assign flush       = pop_fire && mispredict;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      update              <= 1'b0;
      correct             <= 1'b0;
      pc_update           <= '0;
      previous_prediction <= snt;
      calculated_target   <= '0;
      redirect            <= 1'b0;
      redirect_pc         <= '0;
      order_err           <= 1'b0;
    end else begin
      update   <= pop_fire && resolve_is_branch;
      redirect <= flush;
      if (pop_fire) begin
        correct             <= (pred_taken == resolve_taken);
        pc_update           <= head.pc;
        previous_prediction <= head.prediction;
        calculated_target   <= resolve_target;
        if (mispredict) redirect_pc <= actual_next;
        if (resolve_pc != head.pc) order_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized + directed bench: a queue-based reference model predicts each
// training/redirect pulse into a scoreboard that a negedge monitor drains.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc, fetch_pc_prediction;
  logic [1:0]  fetch_prediction;
  logic        full, empty;
  logic [2:0]  count;
  logic        resolve_valid, resolve_is_branch, resolve_taken;
  logic [31:0] resolve_pc, resolve_target;
  logic        update, correct, redirect, order_err;
  logic [31:0] pc_update, calculated_target, redirect_pc;
  logic [1:0]  previous_prediction;

  branch_resolve_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_prediction(fetch_prediction),
    .fetch_pc_prediction(fetch_pc_prediction),
    .full(full), .empty(empty), .count(count),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_is_branch(resolve_is_branch),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .update(update), .correct(correct), .pc_update(pc_update),
    .previous_prediction(previous_prediction), .calculated_target(calculated_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .order_err(order_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  pr;
    logic [31:0] pcp;
  } ent_t;

  typedef struct {
    bit          upd;
    bit          cor;
    logic [31:0] pc;
    logic [1:0]  pr;
    logic [31:0] tgt;
    bit          rd;
    logic [31:0] rpc;
  } exp_t;

  ent_t mq[$];
  exp_t sbq[$];
  bit   m_oerr;
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Monitor: every pulse the DUT shows must match the oldest predicted one.
  always @(negedge clk) begin
    if (rst === 1'b1 && (update === 1'b1 || redirect === 1'b1)) begin
      if (sbq.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL spurious_pulse: got update=%b redirect=%b want none", update, redirect);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("update", {31'd0, update}, {31'd0, e.upd});
        chk("redirect", {31'd0, redirect}, {31'd0, e.rd});
        if (e.upd) begin
          chk("correct", {31'd0, correct}, {31'd0, e.cor});
          chk("pc_update", pc_update, e.pc);
          chk("previous_prediction", {30'd0, previous_prediction}, {30'd0, e.pr});
          chk("calculated_target", calculated_target, e.tgt);
        end
        if (e.rd) chk("redirect_pc", redirect_pc, e.rpc);
      end
    end
  end

  // Reference step applied at each rising edge.
  task automatic model_step(input bit fv, input ent_t fe, input bit rv, input logic [31:0] rpc,
                            input bit isb, input bit tk, input logic [31:0] tgt);
    bit was_full, flushed;
    was_full = (mq.size() == DEPTH);
    flushed  = 1'b0;
    if (rv && mq.size() != 0) begin
      ent_t h;
      exp_t e;
      logic [31:0] nxt;
      h   = mq.pop_front();
      nxt = (isb && tk) ? tgt : h.pc + 32'd4;
      e.upd = isb;
      e.cor = ((h.pr >= 2'd2) == tk);
      e.pc  = h.pc;
      e.pr  = h.pr;
      e.tgt = tgt;
      e.rd  = (h.pcp != nxt);
      e.rpc = nxt;
      if (rpc != h.pc) m_oerr = 1'b1;
      if (e.upd || e.rd) sbq.push_back(e);
      if (e.rd) begin
        mq.delete();
        flushed = 1'b1;
      end
    end
    if (fv && !was_full && !flushed) mq.push_back(fe);
  endtask

  task automatic cyc(input bit fv, input logic [31:0] fpc, input logic [1:0] fpr,
                     input logic [31:0] fpcp, input bit rv, input logic [31:0] rpc,
                     input bit isb, input bit tk, input logic [31:0] tgt);
    ent_t fe;
    fe = '{pc: fpc, pr: fpr, pcp: fpcp};
    fetch_valid = fv; fetch_pc = fpc; fetch_prediction = fpr; fetch_pc_prediction = fpcp;
    resolve_valid = rv; resolve_pc = rpc; resolve_is_branch = isb;
    resolve_taken = tk; resolve_target = tgt;
    @(posedge clk);
    model_step(fv, fe, rv, rpc, isb, tk, tgt);
    @(negedge clk);
    chk("count", {29'd0, count}, mq.size());
    chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
    chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
    chk("order_err", {31'd0, order_err}, {31'd0, m_oerr});
  endtask

  task automatic push(input logic [31:0] pc, input logic [1:0] pr, input logic [31:0] pcp);
    cyc(1, pc, pr, pcp, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic [31:0] rpc, input bit isb, input bit tk, input logic [31:0] tgt);
    cyc(0, 0, 0, 0, 1, rpc, isb, tk, tgt);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; m_oerr = 1'b0;
    fetch_valid = 0; fetch_pc = 0; fetch_prediction = 0; fetch_pc_prediction = 0;
    resolve_valid = 0; resolve_pc = 0; resolve_is_branch = 0; resolve_taken = 0; resolve_target = 0;
    #12;
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_update", {31'd0, update}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_order_err", {31'd0, order_err}, 32'd0);
    chk("rst_correct", {31'd0, correct}, 32'd0);
    chk("rst_pc_update", pc_update, 32'd0);
    chk("rst_prev_pred", {30'd0, previous_prediction}, 32'd0);
    chk("rst_calc_target", calculated_target, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    @(negedge clk); rst = 1'b1;
    idle();

    // correct taken prediction
    push(32'h100, 2'd2, 32'h180);
    resolve(32'h100, 1, 1, 32'h180);
    idle();
    // wrong direction -> redirect and flush
    push(32'h200, 2'd3, 32'h240);
    resolve(32'h200, 1, 0, 32'h240);
    idle();
    // fill, overflow, pop+push while full
    for (int i = 0; i < 5; i++) push(32'h1000 + 32'(i) * 4, 2'd0, 32'h1004 + 32'(i) * 4);
    cyc(1, 32'h2000, 2'd1, 32'h2004, 1, 32'h1000, 0, 0, 0);
    while (mq.size() != 0) resolve(mq[0].pc, 0, 0, 0);
    idle();
    // non-branch aliased to a taken target
    push(32'h300, 2'd0, 32'h340);
    resolve(32'h300, 0, 0, 32'h0);
    idle();
    // resolve on empty, then PC order violation
    resolve(32'h700, 1, 1, 32'h900);
    push(32'h504, 2'd1, 32'h508);
    resolve(32'h500, 1, 0, 32'h0);
    idle();
    idle();

    // randomized traffic, including the 32-bit pc+4 wrap
    for (int n = 0; n < 400; n++) begin
      bit fv, rv, isb, tk;
      logic [31:0] fpc, fpcp, rpc, tgt;
      fv  = ($urandom_range(0, 99) < 60);
      fpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      fpcp = $urandom_range(0, 1) ? fpc + 32'd4 : ($urandom & 32'hFFFF_FFFC);
      rv  = ($urandom_range(0, 99) < 50);
      isb = ($urandom_range(0, 99) < 80);
      tk  = $urandom_range(0, 1);
      tgt = $urandom & 32'hFFFF_FFFC;
      rpc = $urandom;
      if (mq.size() != 0) begin
        if ($urandom_range(0, 1)) tgt = mq[0].pcp;
        rpc = ($urandom_range(0, 99) < 3) ? (mq[0].pc ^ 32'h4) : mq[0].pc;
      end
      cyc(fv, fpc, 2'($urandom_range(0, 3)), fpcp, rv, rpc, isb, tk, tgt);
    end
    while (mq.size() != 0) resolve(mq[0].pc, 0, 0, 0);
    idle();
    idle();

    // async reset mid-cycle with entries queued and an update pulse pending
    for (int i = 0; i < 4; i++) push(32'h4000 + 32'(i) * 4, 2'd0, 32'h4004 + 32'(i) * 4);
    fetch_valid = 0; resolve_valid = 1; resolve_pc = 32'h4000;
    resolve_is_branch = 1; resolve_taken = 0; resolve_target = 32'h0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    mq.delete(); sbq.delete(); m_oerr = 1'b0;
    resolve_valid = 0;
    #1;
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_update", {31'd0, update}, 32'd0);
    chk("arst_redirect", {31'd0, redirect}, 32'd0);
    chk("arst_order_err", {31'd0, order_err}, 32'd0);
    @(negedge clk); rst = 1'b1;
    push(32'h6000, 2'd3, 32'h6100);
    resolve(32'h6000, 1, 1, 32'h6100);
    idle();
    idle();

    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
